imem_uart_loader: RTL

IMEM_UART_LOADER -- requirements
Module: imem_uart_loader

---
 rtl/imem_uart_loader_if.sv | 10 +
 rtl/imem_uart_loader.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/imem_uart_loader_if.sv
// Instruction-memory write port driven by the UART boot loader.
// The loader is the master; the memory (or a bench) is the slave.
interface imem_uart_loader_if;
    logic        imem_we;
    logic [6:0]  imem_addr;
    logic [31:0] imem_wdata;

    modport master (output imem_we, output imem_addr, output imem_wdata);
    modport slave  (input  imem_we, input  imem_addr, input  imem_wdata);
endinterface

// File: rtl/imem_uart_loader.sv
// UART 8N1 boot loader: a header byte N is followed by N little-endian words.
// The CPU is held in reset until all N words are written to instruction memory.
module imem_uart_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DEPTH_WORDS  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 start,
    imem_uart_loader_if.master   mem,
    output logic                 cpu_hold,
    output logic                 done,
    output logic                 frame_err,
    output logic [5:0]           word_count
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {IDLE, WAIT_HDR, LOAD, DONE, ERR} ld_state_t;

    rx_state_t rx_state, rx_next;
    ld_state_t ld_state, ld_next;

    logic          rx_q1, rx_s;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    rx_byte;
    logic          byte_valid, rx_ferr;
    logic          half_tick, full_tick;

    logic [1:0]    byte_idx;
    logic [23:0]   asm_word;
    logic [7:0]    n_words;
    logic          hdr_ok, last_word, arm;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_q1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            rx_q1 <= rx;
            rx_s  <= rx_q1;
        end
    end

    assign half_tick = (cnt == CW'(CLKS_PER_BIT / 2 - 1));
    assign full_tick = (cnt == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rx_state <= RX_IDLE;
        else        rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        unique case (rx_state)
            RX_IDLE:  if (!rx_s) rx_next = RX_START;
            RX_START: if (half_tick) rx_next = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:  if (full_tick && bit_idx == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (full_tick) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    // Counter restarts on every sample point so data bits land mid-bit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt        <= '0;
            bit_idx    <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            rx_ferr    <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            rx_ferr    <= 1'b0;
            if (rx_state == RX_IDLE ||
                (rx_state == RX_START && half_tick) ||
                (rx_state != RX_START && full_tick))
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            if (rx_state == RX_START) bit_idx <= '0;
            if (rx_state == RX_DATA && full_tick) begin
                rx_byte <= {rx_s, rx_byte[7:1]};
                bit_idx <= bit_idx + 1'b1;
            end
            if (rx_state == RX_STOP && full_tick) begin
                byte_valid <= rx_s;
                rx_ferr    <= ~rx_s;
            end
        end
    end

    assign hdr_ok    = (rx_byte != 8'd0) && (int'(rx_byte) <= DEPTH_WORDS);
    assign last_word = ({2'b00, word_count} == n_words);
    assign arm       = start &&
                       (ld_state == IDLE || ld_state == DONE || ld_state == ERR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ld_state <= IDLE;
        else        ld_state <= ld_next;
    end

    always_comb begin
        ld_next = ld_state;
        unique case (ld_state)
            IDLE, DONE, ERR: if (start) ld_next = WAIT_HDR;
            WAIT_HDR: begin
                if (rx_ferr)         ld_next = ERR;
                else if (byte_valid) ld_next = hdr_ok ? LOAD : ERR;
            end
            LOAD: begin
                if (rx_ferr)                         ld_next = ERR;
                else if (mem.imem_we && last_word)   ld_next = DONE;
            end
            default: ld_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem.imem_we    <= 1'b0;
            mem.imem_addr  <= '0;
            mem.imem_wdata <= '0;
            word_count     <= '0;
            byte_idx       <= '0;
            asm_word       <= '0;
            n_words        <= '0;
        end else begin
            mem.imem_we <= 1'b0;
            if (arm) begin
                word_count <= '0;
                byte_idx   <= '0;
            end
            if (ld_state == WAIT_HDR && byte_valid && hdr_ok)
                n_words <= rx_byte;
            if (ld_state == LOAD && byte_valid) begin
                byte_idx <= byte_idx + 1'b1;
                if (byte_idx == 2'd3) begin
                    mem.imem_we    <= 1'b1;
                    mem.imem_addr  <= {word_count[4:0], 2'b00};
                    mem.imem_wdata <= {rx_byte, asm_word};
                    word_count     <= word_count + 1'b1;
                end else begin
                    asm_word[{byte_idx, 3'b000} +: 8] <= rx_byte;
                end
            end
        end
    end

    assign done      = (ld_state == DONE);
    assign cpu_hold  = (ld_state != DONE);
    assign frame_err = (ld_state == ERR);

endmodule
